// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_pkg: shared types and constants for the memory-stage bus controller.
//   state_t    - controller FSM states (IDLE, REQ, RESP, DONE)
//   F3_*       - RV32I load/store funct3 encodings used by load extraction
//   word_align - clears the byte offset of an address for the word bus
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // The data bus is word addressed; byte lanes are selected by the strobe.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_if: data-memory request/grant/response bus.
//   master (controller): drives bus_req, bus_we, bus_addr, bus_wdata, bus_strb;
//                        receives bus_gnt, bus_rvalid, bus_rdata
//   slave  (memory)    : the mirror image
interface mem_bus_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_strb;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_strb,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_strb,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/mem_bus_ctrl_load_extract.sv
// load_extract: combinational load-result formatter.
//   i_rdata    - raw read word from the bus
//   i_offset   - byte offset of the original access (addr[1:0])
//   i_funct3   - RV32I load funct3
//   o_data     - selected byte/half/word, sign- or zero-extended
module load_extract
    import mem_bus_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte lane and half-word lane.
    always_comb begin
        w_byte = 8'h00;
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        if (i_offset[1]) begin
            w_half = i_rdata[31:16];
        end else begin
            w_half = i_rdata[15:0];
        end
    end

    // Extend the selected lane according to the load type.
    always_comb begin
        o_data = 32'h0000_0000;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'h00_0000, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'h0000, w_half};
            F3_W:    o_data = i_rdata;
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: memory-stage bus controller.
//   clk, rst_n                 - core clock, async active-low reset
//   mem_valid, mem_re, mem_we  - MEM-stage access qualifiers
//   addr, funct3, wdata, strobe- access from the load/store decoder (strobe 0 = misaligned)
//   bus (mem_bus_if.master)    - data-memory request/grant/response bus
//   stall                      - hold IF..MEM while a transaction is outstanding
//   done                       - one-cycle pulse when the access completes
//   load_data                  - extended load result (0 for stores)
//   misalign                   - one-cycle pulse for a misaligned access
module mem_bus_ctrl
    import mem_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [3:0]  strobe,
    mem_bus_if.master   bus,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misalign
);

    state_t      r_state;
    state_t      w_next;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_strb;
    logic [2:0]  r_funct3;
    logic [1:0]  r_offset;
    logic [31:0] r_load_data;
    logic        w_access;
    logic        w_launch;
    logic [31:0] w_ext;

    assign w_access = mem_valid & (mem_re | mem_we);
    assign w_launch = w_access & (strobe != 4'b0000);

    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_wdata = r_bus_wdata;
    assign bus.bus_strb  = r_bus_strb;
    assign load_data     = r_load_data;

    load_extract u_load_extract (
        .i_rdata  (bus.bus_rdata),
        .i_offset (r_offset),
        .i_funct3 (r_funct3),
        .o_data   (w_ext)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and pipeline-facing control outputs.
    always_comb begin
        w_next   = r_state;
        stall    = 1'b0;
        done     = 1'b0;
        misalign = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_next = REQ;
                    stall  = 1'b1;
                end else if (w_access) begin
                    misalign = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus.bus_gnt) begin
                    // Stores and loads whose data arrives with the grant finish at once.
                    if (r_bus_we || bus.bus_rvalid) begin
                        w_next = DONE;
                    end else begin
                        w_next = RESP;
                    end
                end else begin
                    w_next = REQ;
                end
            end
            RESP: begin
                stall = 1'b1;
                if (bus.bus_rvalid) begin
                    w_next = DONE;
                end else begin
                    w_next = RESP;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Bus request registers and load-result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0000_0000;
            r_bus_wdata <= 32'h0000_0000;
            r_bus_strb  <= 4'b0000;
            r_funct3    <= 3'b000;
            r_offset    <= 2'b00;
            r_load_data <= 32'h0000_0000;
        end else begin
            case (r_state)
                IDLE: begin
                    // Request is raised together with the move into REQ so it is
                    // already registered while the FSM waits for the grant.
                    if (w_launch) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= mem_we;
                        r_bus_addr  <= word_align(addr);
                        r_bus_wdata <= wdata;
                        r_bus_strb  <= strobe;
                        r_funct3    <= funct3;
                        r_offset    <= addr[1:0];
                    end
                end
                REQ: begin
                    if (bus.bus_gnt) begin
                        r_bus_req <= 1'b0;
                        if (r_bus_we) begin
                            r_load_data <= 32'h0000_0000;
                        end else if (bus.bus_rvalid) begin
                            r_load_data <= w_ext;
                        end
                    end
                end
                RESP: begin
                    if (bus.bus_rvalid) begin
                        r_load_data <= w_ext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
